pkt_arbiter: RTL

PKT_ARBITER -- requirements
Module: pkt_arbiter

---
 rtl/pkt_pkg.sv | 31 +++
 rtl/rr_pick.sv | 36 +++
 rtl/pkt_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_pkg : packet header field positions and arbiter state encoding   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pkt_pkg;

   localparam int PKT_W   = 128;

   // Header field positions; they assume the default 128-bit packet width.
   localparam int SYNC_HI = 127;
   localparam int SYNC_LO = 123;
   localparam int SGL_BIT = 122;
   localparam int MID_HI  = 121;
   localparam int MID_LO  = 118;
   localparam int CMD_BIT = 115;

   localparam int SYNC_W  = SYNC_HI - SYNC_LO + 1;
   localparam logic [SYNC_W-1:0] SYNC_PATTERN = '1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   function automatic logic pkt_sync_ok(input logic [SYNC_W-1:0] sync);
      return sync == SYNC_PATTERN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : round-robin winner search from a start pointer, wrapping   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   logic [IDX_W-1:0] pos;

   // Walk start, start+1, ... modulo N; the first asserted request wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'((int'(start) + k) % N);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_arbiter : round-robin packet arbiter with one-entry output reg,  |
// | malformed-packet drop counter. CMD_PRIORITY_EN: is_cmd class first.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pkt_arbiter #(
   parameter int N_SRC = 4,
   parameter int PKT_W = pkt_pkg::PKT_W
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_mask,
   input  logic [N_SRC-1:0]           src_valid,
   input  logic [N_SRC*PKT_W-1:0]     src_data,
   output logic [N_SRC-1:0]           src_ready,
   output logic                       out_valid,
   output logic [PKT_W-1:0]           out_data,
   output logic [$clog2(N_SRC)-1:0]   out_src,
   input  logic                       out_ready,
   output logic [15:0]                err_cnt
);
   import pkt_pkg::*;

   localparam int IDX_W = $clog2(N_SRC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PKT_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0] out_src_q, out_src_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   logic [N_SRC-1:0] all_grant;
   logic [IDX_W-1:0] all_idx;
   logic [N_SRC-1:0] win_grant;
   logic [IDX_W-1:0] win_idx;
   logic [PKT_W-1:0] win_data;
   logic [N_SRC-1:0] grant_vec;
   logic             can_load;

   rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_pick_all (
      .req   (src_valid),
      .start (rr_ptr_q),
      .grant (all_grant),
      .idx   (all_idx)
   );

`ifdef CMD_PRIORITY_EN
   logic [N_SRC-1:0] cmd_req;
   logic [N_SRC-1:0] cmd_grant;
   logic [IDX_W-1:0] cmd_idx;

   for (genvar i = 0; i < N_SRC; i++) begin : g_cmd_req
      assign cmd_req[i] = src_valid[i] & src_data[i*PKT_W + CMD_BIT];
   end

   // Same shared pointer for both classes; the command class wins if non-empty.
   rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_pick_cmd (
      .req   (cmd_req),
      .start (rr_ptr_q),
      .grant (cmd_grant),
      .idx   (cmd_idx)
   );

   assign win_grant = (|cmd_req) ? cmd_grant : all_grant;
   assign win_idx   = (|cmd_req) ? cmd_idx   : all_idx;
`else
   assign win_grant = all_grant;
   assign win_idx   = all_idx;
`endif

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_data = src_data[i*PKT_W +: PKT_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      err_cnt_d  = err_cnt_q;
      grant_vec  = '0;
      can_load   = (state_q == ST_IDLE) || out_ready;
      if (can_load) begin
         // A held packet leaves this cycle; a fresh winner may replace it.
         state_d = ST_IDLE;
         if (|src_valid) begin
            grant_vec = win_grant;
            rr_ptr_d  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            if (pkt_sync_ok(win_data[SYNC_HI:SYNC_LO])) begin
               state_d    = ST_HOLD;
               out_data_d = win_data;
               out_src_d  = win_idx;
            end else if (err_cnt_q != 16'hFFFF) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
      if (!sys_rst_mask) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         out_data_q <= '0;
         out_src_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Accept strobe is combinational so a source sees its grant in the request cycle.
   assign src_ready = grant_vec & {N_SRC{sys_rst_mask}};
   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
